branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
// - Pipeline controller that sequences ID-stage branch resolution around the branch decision unit.
// - Detects RAW hazards between branch operands (rs/rt) and older EX/MEM instructions.
// - Stalls IF/ID and bubbles EX until forwarding can supply the operands.
// - Then enables evaluation, redirects the PC, squashes the wrong-path fetch and requests link writeback.
// PARAMETERS
// - DELAY_SLOT  0   1: architectural delay slot, so oFlushIF is never asserted; 0: flush wrong-path fetch on taken branch
// - CNT_W       32  width of the statistics counters
// PORTS
// - iCLK          in   1      core clock
// - iRSTn         in   1      reset; async assert, active-low
// - iFreeze       in   1      global pipeline freeze (memory wait)
// - iBranchID     in   1      conditional branch present in ID (control branch signal)
// - iUsesRt       in   1      branch compares rt (BEQ/BNE); 0 means rt is a REGIMM code, not a register
// - iRsID         in   5      rs of branch in ID
// - iRtID         in   5      rt of branch in ID
// - iRegWriteEX   in   1      EX instruction writes a register
// - iMemReadEX    in   1      EX instruction is a load
// - iRdEX         in   5      EX destination register
// - iMemReadMEM   in   1      MEM instruction is a load
// - iRdMEM        in   5      MEM destination register
// - iTaken        in   1      branch decision result (decision unit oBranch)
// - iLink         in   1      branch links (decision unit oLink)
// - oBranchEval   out  1      enable to decision unit (its branch control input)
// - oStall        out  1      hold PC and IF/ID
// - oBubbleEX     out  1      insert NOP into ID/EX
// - oPCSrcBranch  out  1      select branch target for next PC
// - oFlushIF      out  1      squash the IF/ID entry being written
// - oLinkWrite    out  1      write PC+8 to $ra
// - oTakenCnt     out  CNT_W  taken branches
// - oNTakenCnt    out  CNT_W  not-taken branches
// - oStallCnt     out  CNT_W  branch-induced stall cycles
// BEHAVIOUR
// Reset:
// - State S_IDLE; all outputs 0; counters 0.
// - Reset asserted mid-stall abandons the sequence immediately.
// Hazard terms (rt terms only count when iUsesRt=1; a destination of $0 never matches):
// - hEXld  = iMemReadEX & (iRdEX matches rs or rt)
// - hEXalu = iRegWriteEX & ~iMemReadEX & (iRdEX matches)
// - hMEMld = iMemReadMEM & (iRdMEM matches)
// FSM (2-bit; all outputs combinational from state and inputs):
// - S_IDLE
//   - iBranchID & hEXld: oStall=1, oBubbleEX=1 -> S_STALL1.
//   - else iBranchID & (hEXalu|hMEMld): oStall=1, oBubbleEX=1 -> S_EVAL.
//   - else iBranchID: evaluate this cycle -> S_IDLE.
// - S_STALL1: oStall=1, oBubbleEX=1 -> S_EVAL.
// - S_EVAL: evaluate unconditionally; forwarding now covers the operand -> S_IDLE.
// Evaluate cycle:
// - oBranchEval=1; oPCSrcBranch=iTaken; oFlushIF=iTaken & (DELAY_SLOT==0).
// - oLinkWrite=iLink, regardless of iTaken (AL semantics).
// Latency:
// - 0 stalls with no hazard; 1 stall for ALU-in-EX or load-in-MEM; 2 stalls for load-in-EX.
// - Stall cycles outside S_IDLE do not re-check hazards.
// iFreeze=1:
// - State holds.
// - oBranchEval, oPCSrcBranch, oFlushIF, oLinkWrite forced 0; oStall/oBubbleEX forced 0.
// - Counters hold; evaluation is deferred to the first unfrozen cycle.
// iFreeze has priority over every simultaneous event except reset.
// Counters:
// - Increment on evaluate (taken / not taken) and on each stall cycle.
// - Wrap modulo 2^CNT_W.
// CONFIGURATION
// - BRANCH_SEQ_STATS_EN defined: the three counters are implemented.
// - Undefined: no counter flops; oTakenCnt, oNTakenCnt and oStallCnt are tied to 0; ports remain.
// STRUCTURE
// - Shared constants header: state encodings (S_IDLE, S_STALL1, S_EVAL), register $0 index, CNT_W default.
// - Sub-module branch_hazard_cmp: combinational; produces hEXld, hEXalu, hMEMld.
// - Top holds FSM, output decode and optional counters.
// TESTING
// - No hazard, iBranchID=1, iTaken=1 -> same cycle oBranchEval=1, oPCSrcBranch=1, oFlushIF=1, oStall=0; with DELAY_SLOT=1, oFlushIF=0.
// - iRegWriteEX=1, iRdEX=8, iRsID=8 -> cycle0 oStall=oBubbleEX=1; cycle1 oBranchEval=1; oStallCnt=1.
// - iMemReadEX=1, iRdEX=9, iRtID=9, iUsesRt=1 -> 2 stall cycles, then evaluate; same with iUsesRt=0 -> 0 stalls.
// - iRdEX=0, iRsID=0, iRegWriteEX=1 -> no stall; BGEZAL with iLink=1, iTaken=0 -> oLinkWrite=1, oPCSrcBranch=0.
// - iFreeze=1 for 3 cycles while in S_STALL1 -> state held, all outputs 0; evaluate 2 cycles after release.
// - iRSTn=0 asynchronously in S_STALL1 -> outputs 0 before next edge, S_IDLE; counters 0; next branch sequences normally.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// branch_sequencer_pkg: shared state encodings, register constants and the operand-match helper.
package branch_sequencer_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STALL1 = 2'd1;
    localparam logic [1:0] S_EVAL   = 2'd2;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         CNT_W_DEF = 32;

    // rt is only a register operand for BEQ/BNE; for REGIMM it carries an opcode.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/branch_hazard_cmp.sv
// branch_hazard_cmp: RAW hazard terms between the ID branch operands and older EX/MEM instructions.
module branch_hazard_cmp
    import branch_sequencer_pkg::*;
(
    input  logic       iUsesRt,
    input  logic [4:0] iRsID,
    input  logic [4:0] iRtID,
    input  logic       iRegWriteEX,
    input  logic       iMemReadEX,
    input  logic [4:0] iRdEX,
    input  logic       iMemReadMEM,
    input  logic [4:0] iRdMEM,
    output logic       oHazEXld,
    output logic       oHazEXalu,
    output logic       oHazMEMld
);

    logic match_ex;
    logic match_mem;

    assign match_ex  = reg_match(iRdEX, iRsID, iRtID, iUsesRt);
    assign match_mem = reg_match(iRdMEM, iRsID, iRtID, iUsesRt);

    assign oHazEXld  = iMemReadEX & match_ex;
    assign oHazEXalu = iRegWriteEX & ~iMemReadEX & match_ex;
    assign oHazMEMld = iMemReadMEM & match_mem;

endmodule

// File: rtl/branch_sequencer.sv
// branch_sequencer: stalls ID-stage branches until forwarding covers their operands, then evaluates,
// redirects and flushes. Statistics counters exist only when BRANCH_SEQ_STATS_EN is defined.
module branch_sequencer
    import branch_sequencer_pkg::*;
#(
    parameter int DELAY_SLOT = 0,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             iFreeze,
    input  logic             iBranchID,
    input  logic             iUsesRt,
    input  logic [4:0]       iRsID,
    input  logic [4:0]       iRtID,
    input  logic             iRegWriteEX,
    input  logic             iMemReadEX,
    input  logic [4:0]       iRdEX,
    input  logic             iMemReadMEM,
    input  logic [4:0]       iRdMEM,
    input  logic             iTaken,
    input  logic             iLink,
    output logic             oBranchEval,
    output logic             oStall,
    output logic             oBubbleEX,
    output logic             oPCSrcBranch,
    output logic             oFlushIF,
    output logic             oLinkWrite,
    output logic [CNT_W-1:0] oTakenCnt,
    output logic [CNT_W-1:0] oNTakenCnt,
    output logic [CNT_W-1:0] oStallCnt
);

    logic [1:0] state_q, state_d;
    logic       h_ex_ld, h_ex_alu, h_mem_ld;
    logic       active, idle_br, eval, stall;

    branch_hazard_cmp u_hazard (
        .iUsesRt    (iUsesRt),
        .iRsID      (iRsID),
        .iRtID      (iRtID),
        .iRegWriteEX(iRegWriteEX),
        .iMemReadEX (iMemReadEX),
        .iRdEX      (iRdEX),
        .iMemReadMEM(iMemReadMEM),
        .iRdMEM     (iRdMEM),
        .oHazEXld   (h_ex_ld),
        .oHazEXalu  (h_ex_alu),
        .oHazMEMld  (h_mem_ld)
    );

    // Gating with iRSTn keeps outputs quiet for the whole reset, not just until the state clears.
    assign active  = iRSTn & ~iFreeze;
    assign idle_br = (state_q == S_IDLE) & iBranchID;
    assign stall   = active & ((idle_br & (h_ex_ld | h_ex_alu | h_mem_ld)) | (state_q == S_STALL1));
    assign eval    = active & ((idle_br & ~(h_ex_ld | h_ex_alu | h_mem_ld)) | (state_q == S_EVAL));

    assign oStall       = stall;
    assign oBubbleEX    = stall;
    assign oBranchEval  = eval;
    assign oPCSrcBranch = eval & iTaken;
    assign oFlushIF     = eval & iTaken & (DELAY_SLOT == 0);
    assign oLinkWrite   = eval & iLink;

    always_comb begin
        state_d = S_IDLE;
        if (iFreeze)
            state_d = state_q;
        else if (state_q == S_IDLE)
            state_d = (iBranchID & h_ex_ld) ? S_STALL1 :
                      (iBranchID & (h_ex_alu | h_mem_ld)) ? S_EVAL : S_IDLE;
        else if (state_q == S_STALL1)
            state_d = S_EVAL;
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

`ifdef BRANCH_SEQ_STATS_EN
    logic [CNT_W-1:0] taken_q, ntaken_q, stall_cnt_q;

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            taken_q     <= '0;
            ntaken_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (eval & iTaken)
                taken_q <= taken_q + CNT_W'(1);
            if (eval & ~iTaken)
                ntaken_q <= ntaken_q + CNT_W'(1);
            if (stall)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign oTakenCnt  = taken_q;
    assign oNTakenCnt = ntaken_q;
    assign oStallCnt  = stall_cnt_q;
`else
    assign oTakenCnt  = '0;
    assign oNTakenCnt = '0;
    assign oStallCnt  = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed scoreboard bench for branch_sequencer (flush and no-flush variants).
module tb_branch_sequencer;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frz, br, ut, rwex, mrex, mrmem, tk, lk;
    logic [4:0]    rs, rt, rdex, rdmem;
    logic          ev0, st0, bb0, pc0, fl0, lw0;
    logic          ev1, st1, bb1, pc1, fl1, lw1;
    logic [CW-1:0] tc0, nc0, sc0, tc1, nc1, sc1;

    logic [5:0]    exp_q[$];
    int            n_asserts = 0;
    int            n_fails   = 0;
    int            m_taken   = 0;
    int            m_ntaken  = 0;
    int            m_stall   = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.DELAY_SLOT(0), .CNT_W(CW)) dut0 (
        .iCLK(clk), .iRSTn(rst_n), .iFreeze(frz), .iBranchID(br), .iUsesRt(ut),
        .iRsID(rs), .iRtID(rt), .iRegWriteEX(rwex), .iMemReadEX(mrex), .iRdEX(rdex),
        .iMemReadMEM(mrmem), .iRdMEM(rdmem), .iTaken(tk), .iLink(lk),
        .oBranchEval(ev0), .oStall(st0), .oBubbleEX(bb0), .oPCSrcBranch(pc0),
        .oFlushIF(fl0), .oLinkWrite(lw0), .oTakenCnt(tc0), .oNTakenCnt(nc0), .oStallCnt(sc0)
    );

    branch_sequencer #(.DELAY_SLOT(1), .CNT_W(CW)) dut1 (
        .iCLK(clk), .iRSTn(rst_n), .iFreeze(frz), .iBranchID(br), .iUsesRt(ut),
        .iRsID(rs), .iRtID(rt), .iRegWriteEX(rwex), .iMemReadEX(mrex), .iRdEX(rdex),
        .iMemReadMEM(mrmem), .iRdMEM(rdmem), .iTaken(tk), .iLink(lk),
        .oBranchEval(ev1), .oStall(st1), .oBubbleEX(bb1), .oPCSrcBranch(pc1),
        .oFlushIF(fl1), .oLinkWrite(lw1), .oTakenCnt(tc1), .oNTakenCnt(nc1), .oStallCnt(sc1)
    );

    // Vector layout: {eval, stall, bubble, pcsrc, flush, link}
    task automatic clr();
        frz = 0; br = 0; ut = 0; rs = 0; rt = 0; rwex = 0; mrex = 0; rdex = 0;
        mrmem = 0; rdmem = 0; tk = 0; lk = 0;
    endtask

    task automatic chk(input logic [5:0] obs, input logic [5:0] exp, input string tag);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input logic [CW-1:0] obs, input int exp, input string tag);
        logic [CW-1:0] e;
`ifdef BRANCH_SEQ_STATS_EN
        e = CW'(exp);
`else
        e = '0;
`endif
        n_asserts++;
        assert (obs === e) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
        end
    endtask

    task automatic step(input logic [5:0] exp, input string tag);
        logic [5:0] e;
        exp_q.push_back(exp);
        #2;
        e = exp_q.pop_front();
        chk({ev0, st0, bb0, pc0, fl0, lw0}, e, {tag, "/ds0"});
        chk({ev1, st1, bb1, pc1, fl1, lw1}, e & 6'b111101, {tag, "/ds1"});
        @(negedge clk);
        if (e[5] & e[2]) m_taken++;
        if (e[5] & ~e[2]) m_ntaken++;
        if (e[4]) m_stall++;
    endtask

    task automatic chk_counters(input string tag);
        chk_cnt(tc0, m_taken, {tag, "/taken"});
        chk_cnt(nc0, m_ntaken, {tag, "/ntaken"});
        chk_cnt(sc0, m_stall, {tag, "/stall"});
    endtask

    initial begin
        clr();
        rst_n = 0;
        br = 1; tk = 1; lk = 1;
        repeat (2) @(negedge clk);
        chk({ev0, st0, bb0, pc0, fl0, lw0}, 6'b000000, "reset_outputs");
        chk_counters("reset");
        clr();
        rst_n = 1;
        @(negedge clk);

        step(6'b000000, "idle");

        br = 1; tk = 1;
        step(6'b100110, "nohaz_taken");

        clr(); br = 1; rwex = 1; rdex = 8; rs = 8;
        step(6'b011000, "alu_ex_stall");
        tk = 0;
        step(6'b100000, "alu_ex_eval");
        chk_counters("after_alu");

        clr(); br = 1; mrex = 1; rdex = 9; rt = 9; ut = 1;
        step(6'b011000, "ld_ex_stall0");
        step(6'b011000, "ld_ex_stall1");
        tk = 1; lk = 1;
        step(6'b100111, "ld_ex_eval");

        clr(); br = 1; mrex = 1; rdex = 9; rt = 9; ut = 0;
        step(6'b100000, "ld_ex_rt_regimm");

        clr(); br = 1; rwex = 1; rdex = 0; rs = 0; lk = 1;
        step(6'b100001, "zero_reg_link");

        clr(); br = 1; mrmem = 1; rdmem = 5; rt = 5; ut = 1;
        step(6'b011000, "ld_mem_stall");
        mrmem = 0; tk = 1;
        step(6'b100110, "ld_mem_eval");
        chk_counters("mid");

        clr(); br = 1; mrex = 1; rdex = 3; rs = 3;
        step(6'b011000, "frz_stall0");
        frz = 1; tk = 1;
        step(6'b000000, "frz_hold0");
        step(6'b000000, "frz_hold1");
        step(6'b000000, "frz_hold2");
        chk_counters("frozen");
        frz = 0;
        step(6'b011000, "frz_rel_stall");
        step(6'b100110, "frz_rel_eval");

        clr(); br = 1; frz = 1; tk = 0;
        step(6'b000000, "frz_idle");
        frz = 0;
        step(6'b100000, "frz_idle_eval");
        chk_counters("before_arst");

        clr(); br = 1; mrex = 1; rdex = 4; rs = 4;
        step(6'b011000, "arst_stall0");
        rst_n = 0;
        #1;
        chk({ev0, st0, bb0, pc0, fl0, lw0}, 6'b000000, "arst_outputs");
        m_taken = 0; m_ntaken = 0; m_stall = 0;
        chk_counters("arst");
        @(negedge clk);
        rst_n = 1;
        clr(); br = 1; tk = 1;
        step(6'b100110, "post_arst_taken");
        clr(); br = 1; rwex = 1; rdex = 7; rt = 7; ut = 1;
        step(6'b011000, "post_arst_stall");
        step(6'b100000, "post_arst_eval");
        chk_counters("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
